// File: rtl/fifo_pop_reader.sv
// rtl/fifo_pop_reader.sv - burst read controller: pops N FIFO words and presents each on a valid/ready port
module fifo_pop_reader #(
    parameter int DATA_WIDTH        = 8,
    parameter int NBITS_FOR_COUNTER = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         abort,
    input  logic [NBITS_FOR_COUNTER-1:0] burst_len,
    input  logic                         fifo_empty,
    input  logic [DATA_WIDTH-1:0]        fifo_data,
    output logic                         fifo_pop,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done,
    output logic [NBITS_FOR_COUNTER-1:0] read_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_PRESENT,
        S_DONE
    } state_t;

    state_t                         r_state;
    state_t                         w_next;
    logic [NBITS_FOR_COUNTER-1:0]   r_remaining;
    logic [NBITS_FOR_COUNTER-1:0]   r_read_count;
    logic [DATA_WIDTH-1:0]          r_out_data;
    logic                           w_handshake;
    logic                           w_accept_start;

    assign w_handshake    = (r_state == S_PRESENT) && out_ready;
    assign w_accept_start = (r_state == S_IDLE) && start && !abort;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (burst_len != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                if (!fifo_empty) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT:  w_next = S_PRESENT;
            S_PRESENT: begin
                if (w_handshake) begin
                    w_next = (r_remaining == NBITS_FOR_COUNTER'(1)) ? S_DONE : S_FETCH;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (abort) begin
            w_next = S_IDLE;
        end
    end

    // A handshake coincident with abort still counts; a word popped before abort in WAIT is dropped.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_remaining  <= '0;
            r_read_count <= '0;
            r_out_data   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept_start) begin
                r_remaining  <= burst_len;
                r_read_count <= '0;
            end
            if ((r_state == S_WAIT) && !abort) begin
                r_out_data <= fifo_data;
            end
            if (w_handshake) begin
                r_read_count <= r_read_count + NBITS_FOR_COUNTER'(1);
                r_remaining  <= r_remaining - NBITS_FOR_COUNTER'(1);
            end
        end
    end

    assign fifo_pop   = (r_state == S_FETCH) && !fifo_empty;
    assign out_valid  = (r_state == S_PRESENT);
    assign busy       = (r_state == S_FETCH) || (r_state == S_WAIT) || (r_state == S_PRESENT);
    assign done       = (r_state == S_DONE);
    assign out_data   = r_out_data;
    assign read_count = r_read_count;

endmodule

// File: tb/tb_fifo_pop_reader.sv
// tb/tb_fifo_pop_reader.sv - directed bench with burst-level scoreboard for fifo_pop_reader
module tb_fifo_pop_reader;
    localparam int DW = 8;
    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NB-1:0] burst_len = '0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          out_ready = 1'b0;
    wire           fifo_pop;
    wire  [DW-1:0] out_data;
    wire           out_valid;
    wire           busy;
    wire           done;
    wire  [NB-1:0] read_count;

    fifo_pop_reader #(.DATA_WIDTH(DW), .NBITS_FOR_COUNTER(NB)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .burst_len(burst_len),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .read_count(read_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [DW-1:0] fq[$];
    int            pop_log[$];
    int            vrise_log[$];
    logic [DW-1:0] hs_log[$];

    // Burst-level model of what the reader owes the outside world
    bit            m_active = 0;
    bit            m_pending = 0;
    bit            m_done_due = 0;
    int            m_count = 0;
    int            m_left = 0;
    logic [DW-1:0] m_exp = '0;
    logic          prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // FIFO storage with registered read data
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_pop && fq.size() > 0) begin
            fifo_data <= fq.pop_front();
        end
        fifo_empty <= (fq.size() == 0);
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("rst_pop", fifo_pop, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_count", read_count, 0);
            chk("rst_data", out_data, 0);
            m_active = 0; m_pending = 0; m_done_due = 0; m_count = 0; m_left = 0;
            prev_valid = 1'b0;
        end else begin
            bit nd;
            chk("m_count", read_count, m_count);
            chk("m_busy", busy, m_active);
            chk("m_done", done, m_done_due);
            if (fifo_pop) begin
                chk("pop_legal", {fifo_empty, m_pending, m_active}, 3'b001);
                pop_log.push_back(cyc);
            end
            if (out_valid) begin
                chk("valid_legal", {m_pending, m_active}, 2'b11);
                chk("m_data", out_data, m_exp);
            end
            if (out_valid && !prev_valid) vrise_log.push_back(cyc);
            prev_valid = out_valid;
            if (done) done_cnt++;
            if (out_valid && out_ready) hs_log.push_back(out_data);
            nd = 0;
            if (fifo_pop && fq.size() > 0) begin
                m_pending = 1;
                m_exp = fq[0];
            end
            if (out_valid && out_ready) begin
                m_count++;
                m_left--;
                m_pending = 0;
                if (m_left == 0) begin
                    m_active = 0;
                    nd = !abort;
                end
            end
            if (abort) begin
                m_active = 0;
                m_pending = 0;
                nd = 0;
            end else if (start && !m_active && !m_done_due) begin
                m_count = 0;
                m_left = int'(burst_len);
                m_active = (burst_len != 0);
                nd = (burst_len == 0);
            end
            m_done_due = nd;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] v);
        fq.push_back(v);
        fifo_empty = 1'b0;
    endtask

    task automatic clear_logs();
        pop_log.delete();
        vrise_log.delete();
        hs_log.delete();
    endtask

    task automatic kick(input logic [NB-1:0] len);
        burst_len = len;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int d0 = done_cnt;
        int n = 0;
        while (done_cnt == d0 && n < 40) begin
            tick(1);
            n++;
        end
        chk(name, done_cnt - d0, 1);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!out_valid && n < 40) begin
            tick(1);
            n++;
        end
        chk(name, out_valid, 1);
    endtask

    initial begin
        int s;
        int p;
        int n;
        int d0;
        #7;
        chk("reset_busy", busy, 0);
        chk("reset_count", read_count, 0);
        chk("reset_data", out_data, 0);
        tick(1);
        reset = 1'b1;
        tick(1);

        // Basic burst
        clear_logs();
        push(8'h11); push(8'h22); push(8'h33);
        out_ready = 1'b1;
        s = cyc;
        d0 = done_cnt;
        kick(3);
        wait_done("t1_done_seen");
        tick(2);
        chk("t1_pop_n", pop_log.size(), 3);
        if (pop_log.size() == 3) begin
            chk("t1_pop0", pop_log[0] - s, 1);
            chk("t1_pop1", pop_log[1] - s, 4);
            chk("t1_pop2", pop_log[2] - s, 7);
        end
        chk("t1_hs_n", hs_log.size(), 3);
        if (hs_log.size() == 3) begin
            chk("t1_d0", hs_log[0], 8'h11);
            chk("t1_d1", hs_log[1], 8'h22);
            chk("t1_d2", hs_log[2], 8'h33);
        end
        chk("t1_done_once", done_cnt - d0, 1);
        chk("t1_count", read_count, 3);

        // Empty stall
        clear_logs();
        kick(2);
        tick(5);
        chk("t2_no_pop", fifo_pop, 0);
        chk("t2_busy", busy, 1);
        chk("t2_pop_log", pop_log.size(), 0);
        push(8'hA5);
        p = cyc;
        tick(3);
        chk("t2_pop_n", pop_log.size(), 1);
        if (vrise_log.size() > 0) chk("t2_present_lat", vrise_log[0] - p, 2);
        else chk("t2_present_seen", 0, 1);
        push(8'hB6);
        wait_done("t2_done_seen");
        chk("t2_count", read_count, 2);
        if (hs_log.size() == 2) begin
            chk("t2_d0", hs_log[0], 8'hA5);
            chk("t2_d1", hs_log[1], 8'hB6);
        end else chk("t2_hs_n", hs_log.size(), 2);

        // Backpressure
        clear_logs();
        push(8'h3C); push(8'h4D);
        out_ready = 1'b0;
        kick(2);
        wait_valid("t3_valid_seen");
        for (int i = 0; i < 4; i++) begin
            chk("t3_hold_data", out_data, 8'h3C);
            chk("t3_hold_valid", out_valid, 1);
            chk("t3_no_pop", fifo_pop, 0);
            chk("t3_count0", read_count, 0);
            tick(1);
        end
        chk("t3_pop_n", pop_log.size(), 1);
        out_ready = 1'b1;
        tick(1);
        chk("t3_count1", read_count, 1);
        chk("t3_hs_n", hs_log.size(), 1);
        wait_done("t3_done_seen");
        chk("t3_count2", read_count, 2);
        if (hs_log.size() == 2) chk("t3_d1", hs_log[1], 8'h4D);

        // Zero length
        clear_logs();
        d0 = done_cnt;
        kick(0);
        chk("t4_done", done, 1);
        chk("t4_busy", busy, 0);
        chk("t4_count", read_count, 0);
        tick(1);
        chk("t4_done_clr", done, 0);
        chk("t4_no_pop", pop_log.size(), 0);
        chk("t4_no_valid", vrise_log.size(), 0);
        chk("t4_done_once", done_cnt - d0, 1);

        // Abort in WAIT of 2nd element
        clear_logs();
        push(8'h51); push(8'h52); push(8'h53); push(8'h54);
        d0 = done_cnt;
        kick(4);
        n = 0;
        while (pop_log.size() < 2 && n < 30) begin
            tick(1);
            n++;
        end
        chk("t5_pop2_seen", pop_log.size(), 2);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        chk("t5_valid", out_valid, 0);
        chk("t5_busy", busy, 0);
        chk("t5_count", read_count, 1);
        tick(3);
        chk("t5_no_done", done_cnt - d0, 0);
        chk("t5_count_kept", read_count, 1);
        chk("t5_hs_n", hs_log.size(), 1);
        if (hs_log.size() > 0) chk("t5_d0", hs_log[0], 8'h51);
        clear_logs();
        kick(1);
        wait_done("t5_restart_done");
        chk("t5_restart_count", read_count, 1);
        if (hs_log.size() == 1) chk("t5_restart_data", hs_log[0], 8'h53);
        else chk("t5_restart_hs_n", hs_log.size(), 1);

        // Asynchronous reset mid-burst
        fq.delete();
        fifo_empty = 1'b1;
        tick(1);
        clear_logs();
        push(8'h66);
        out_ready = 1'b0;
        kick(2);
        wait_valid("t6_valid_seen");
        #1;
        reset = 1'b0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_busy", busy, 0);
        chk("t6_pop", fifo_pop, 0);
        chk("t6_count", read_count, 0);
        chk("t6_data", out_data, 0);
        push(8'h77);
        burst_len = 1;
        start = 1'b1;
        tick(3);
        chk("t6_start_ign", busy, 0);
        start = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(2);
        chk("t6_still_idle", busy, 0);
        chk("t6_pop_n", pop_log.size(), 1);
        out_ready = 1'b1;
        clear_logs();
        kick(1);
        wait_done("t6_after_done");
        if (hs_log.size() == 1) chk("t6_after_data", hs_log[0], 8'h77);
        else chk("t6_after_hs_n", hs_log.size(), 1);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/fifo_pop_reader.md
Name: fifo_pop_reader

Overview:
- Read-side controller for the push/pop FIFO counter block: drains a burst of N elements from the FIFO and forwards them downstream.
- Issues single-cycle pop pulses gated by the FIFO empty flag and captures the registered FIFO read data.
- Presents each element on a valid/ready output interface.
- Sits between the FIFO storage and the matrix-vector datapath, which consumes one vector element per handshake.

Parameters:
DATA_WIDTH, 8, width of FIFO data word and output data
NBITS_FOR_COUNTER, 8, width of burst_len, read_count and the internal remaining counter

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset
start  input  1  1-cycle request to begin a burst; sampled only in IDLE
abort  input  1  synchronous cancel; returns to IDLE from any state
burst_len  input  NBITS_FOR_COUNTER  number of elements to read; latched on accepted start
fifo_empty  input  1  FIFO empty flag
fifo_data  input  DATA_WIDTH  FIFO read data, valid the cycle after a pop
fifo_pop  output  1  pop pulse to FIFO (drives enable_Pop)
out_data  output  DATA_WIDTH  captured element
out_valid  output  1  out_data holds an element not yet accepted
out_ready  input  1  downstream accepts when out_valid & out_ready
busy  output  1  high in FETCH, WAIT, PRESENT
done  output  1  1-cycle pulse at burst completion
read_count  output  NBITS_FOR_COUNTER  elements handed off in current/last burst

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; remaining=0, read_count=0, out_data=0; all 1-bit outputs 0.
- States: IDLE, FETCH, WAIT, PRESENT, DONE.
- IDLE:
  - start=1, burst_len!=0: latch remaining=burst_len, clear read_count, go FETCH.
  - start=1, burst_len==0: clear read_count, go DONE; no pop.
  - Otherwise hold.
- FETCH:
  - fifo_pop = ~fifo_empty, combinational from state; pop is never asserted while empty.
  - fifo_empty=0: go WAIT.
  - fifo_empty=1: stay in FETCH indefinitely.
- WAIT:
  - fifo_data is valid this cycle; register it into out_data at the clock edge.
  - Go PRESENT; fifo_pop=0.
- PRESENT:
  - out_valid=1; out_data held stable until handshake.
  - On out_valid & out_ready: read_count+=1, remaining-=1.
  - If remaining was 1: go DONE, else go FETCH.
  - out_ready low: hold state and data.
- DONE: done=1 for exactly one cycle, busy=0; go IDLE.
- Throughput: minimum 3 cycles per element (FETCH, WAIT, PRESENT) with out_ready held high.
- Pop ordering: each pop is followed by exactly one capture; never two pops without an intervening handshake.
- Output state: out_valid low in all states except PRESENT.
- start while busy: ignored; no relatch of burst_len.
- abort (priority over all transitions except reset):
  - Next state IDLE; out_valid drops next cycle; no done pulse.
  - read_count retains its value.
  - abort in WAIT: the popped element is discarded.
  - abort coincident with a PRESENT handshake: the handshake counts (read_count increments), then IDLE.
- Counters are unsigned and non-wrapping: burst_len up to 2^NBITS_FOR_COUNTER-1; read_count never exceeds the latched burst_len.
- Reset mid-burst: immediate return to reset values; no pop is issued in the reset-release cycle.

Test Plan:
1. Basic burst: FIFO holds 0x11,0x22,0x33; start with burst_len=3; out_ready=1 -> pops at cycles 1,4,7 after start; out_data sequence 0x11,0x22,0x33; done pulse once; read_count=3; fifo_pop asserted exactly 3 times.
2. Empty stall: burst_len=2, FIFO empty for 5 cycles after start -> fifo_pop=0, state FETCH, busy=1; push 0xA5 -> pop next cycle, 0xA5 presented 2 cycles later.
3. Backpressure: out_ready=0 for 4 cycles while out_valid=1 -> out_data stable, no further pop; raise out_ready -> single handshake, read_count increments by exactly 1.
4. Zero length: start with burst_len=0 -> done pulses one cycle later; fifo_pop never asserted; out_valid never asserted; read_count=0.
5. Abort: burst_len=4, assert abort in the WAIT of the 2nd element -> read_count=1, out_valid=0 next cycle, no done; a new start with burst_len=1 then operates normally.
6. Async reset mid-burst: drop reset during PRESENT -> out_valid, busy, fifo_pop go 0 without a clock edge; read_count=0, out_data=0; start ignored until reset=1.
